input_vc_arbiter: RTL and testbench
===================================

# input_vc_arbiter

Per-input-port arbiter that sits directly downstream of the input VC buffers and upstream of the switch allocator. Each cycle it observes the `has_packet` vector of all `vc_num*prio_num` input VCs, together with their head-of-line destination and requested output VC. It selects one VC by strict priority across priority levels and round-robin within a level, presents that VC's request to the switch, and holds the selection from `cts` until the packet's `last`.

## Interface
Parameters:
- `vc_num`, 3, VCs per priority level
- `prio_num`, 2, priority levels; VC index i = p*vc_num + v, higher p wins
- `output_num`, 8, switch outputs
- `timeout_cycles`, 64, REQ timeout (used only with `INPUT_ARB_TIMEOUT_EN`)
- `logVcPrio`, `log2(prio_num*vc_num)`; `logOutput`, `log2(output_num)`

Ports (reset `resetn`, synchronous, active-low; clock `clk`):
- `clk`  in  1  clock
- `resetn`  in  1  synchronous active-low reset
- `has_packet`  in  vc_num*prio_num  head-of-line packet present per VC
- `dest_i`  in  logOutput x (vc_num*prio_num)  destination per VC
- `output_vc_i`  in  logVcPrio x (vc_num*prio_num)  requested output VC per VC
- `cts`  in  1  switch grant for the current request
- `last`  in  1  final flit of the granted packet transferred
- `selected_vc`  out  logVcPrio  registered winning VC index
- `o_req`  out  1  request valid to switch
- `o_dest`  out  logOutput  destination of the selected VC
- `o_output_vc`  out  logVcPrio  output VC of the selected VC
- `o_vc_grant`  out  vc_num*prio_num  one-hot dequeue enable to the VC buffers
- `o_busy`  out  1  packet transfer in progress

## Operation
- FSM states: IDLE, REQ, GRANTED.
- IDLE: if any `has_packet` bit is set, compute the winner combinationally:
  - highest priority level p that has a set bit wins;
  - within p, first set VC at or after `rr_ptr[p]`, wrapping modulo vc_num.
  - Register the winner into `selected_vc`. Latch `dest_i` and `output_vc_i` of the winner into `o_dest` and `o_output_vc`. Go to REQ.
- REQ: `o_req`=1, outputs stable.
  - `cts`=1: go to GRANTED.
  - else, if `has_packet[selected_vc]`=0: go to IDLE; no pointer update.
  - else stay in REQ.
- GRANTED: `o_req`=0, `o_busy`=1, `o_vc_grant[selected_vc]`=1.
  - `last`=1: go to IDLE and set `rr_ptr[p_sel]` to (v_sel+1) mod vc_num.
  - `has_packet` changes during GRANTED are ignored.
- `last` is sampled only in GRANTED. `cts` is sampled only in REQ.
- `cts` and `last` high in the same REQ cycle: go to GRANTED only; `last` is ignored.
- Pointers of non-winning priority levels are never modified.
- `o_dest` and `o_output_vc` hold their latched value in every state other than IDLE-with-winner.

## Timing
- Reset: state=IDLE, every `rr_ptr`=0, `selected_vc`=0, `o_req`=0, `o_dest`=0, `o_output_vc`=0, `o_vc_grant`=0, `o_busy`=0.
- Latency from `has_packet` rising in IDLE to `o_req`=1: 1 cycle.
- Latency from `cts` to `o_busy`/`o_vc_grant`: 1 cycle.
- Latency from `last` to IDLE: 1 cycle. The next `o_req` appears 1 cycle after that, so minimum back-to-back spacing is 2 cycles.
- All outputs are registered. There is no combinational path from an input to an output.
- `resetn` low in any state: forced to IDLE on the next edge and all outputs return to reset values. An in-flight grant is dropped without a pointer update.

## Configuration
- `INPUT_ARB_TIMEOUT_EN` defined:
  - a counter of width `log2(timeout_cycles+1)` runs while in REQ;
  - when it reaches `timeout_cycles` without `cts`, go to IDLE and set `rr_ptr[p_sel]`=(v_sel+1) mod vc_num, so a blocked destination cannot starve its level;
  - the counter clears on entry to REQ.
- Undefined: REQ waits indefinitely and there is no counter logic.

## Test plan
- Single VC: reset, then `has_packet`=6'b000100, `dest_i[2]`=5, `output_vc_i[2]`=2.
  - Next cycle: `selected_vc`=2, `o_req`=1, `o_dest`=5, `o_output_vc`=2.
  - `cts` pulse: next cycle `o_vc_grant`=6'b000100, `o_busy`=1.
  - `last`: next cycle IDLE, `rr_ptr[0]`=0.
- Strict priority: `has_packet`=6'b001001 → `selected_vc`=3 (level 1 beats VC0). After `cts`/`last`, VC0 is served next.
- Round-robin: `has_packet`=6'b000111 held constant, each request granted immediately → `selected_vc` sequence 0,1,2,0.
- Withdrawal: in REQ for VC4 with no `cts`, drop `has_packet[4]` → next cycle `o_req`=0, IDLE, `rr_ptr[1]` unchanged.
- Reset mid-packet: in GRANTED on VC1, `resetn`=0 for 1 cycle → every output is 0 on the next edge; afterwards `has_packet`=6'b000011 selects VC0.
- With `INPUT_ARB_TIMEOUT_EN`, `timeout_cycles`=4: REQ on VC0 with no `cts` → IDLE after 4 cycles. With `has_packet`=6'b000011, the next selection is VC1.

Source files
------------

// File: rtl/input_vc_arbiter.sv
// Per-input-port VC arbiter: strict priority across levels, round-robin within a level,
// holding the winner from cts until last. Optional REQ timeout under `INPUT_ARB_TIMEOUT_EN`.
module input_vc_arbiter #(
  parameter int vc_num         = 3,
  parameter int prio_num       = 2,
  parameter int output_num     = 8,
  parameter int timeout_cycles = 64,
  parameter int logVcPrio      = $clog2(prio_num*vc_num),
  parameter int logOutput      = $clog2(output_num),
  parameter int ptr_w          = (vc_num > 1) ? $clog2(vc_num) : 1,
  parameter int prio_w         = (prio_num > 1) ? $clog2(prio_num) : 1
) (
  input  logic                                           clk,
  input  logic                                           resetn,
  input  logic [vc_num*prio_num-1:0]                     has_packet,
  input  logic [vc_num*prio_num-1:0][logOutput-1:0]      dest_i,
  input  logic [vc_num*prio_num-1:0][logVcPrio-1:0]      output_vc_i,
  input  logic                                           cts,
  input  logic                                           last,
  output logic [logVcPrio-1:0]                           selected_vc,
  output logic                                           o_req,
  output logic [logOutput-1:0]                           o_dest,
  output logic [logVcPrio-1:0]                           o_output_vc,
  output logic [vc_num*prio_num-1:0]                     o_vc_grant,
  output logic                                           o_busy,
  output logic [1:0]                                     o_dbg_state,
  output logic [prio_num*ptr_w-1:0]                      o_dbg_rr_ptr
);

  localparam int N = vc_num * prio_num;

  // Handshake: o_req stays high in REQ until cts is seen; cts is sampled only in REQ and
  // last only in GRANTED. o_vc_grant/o_busy assert the cycle after cts and clear after last.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_GRANTED = 2'd2
  } state_t;

  state_t                        r_state;
  logic [prio_num-1:0][ptr_w-1:0] r_rr_ptr;
  logic [prio_w-1:0]             r_sel_p;
  logic [ptr_w-1:0]              r_sel_v;

  logic                          w_any;
  logic [prio_w-1:0]             w_win_p;
  logic [ptr_w-1:0]              w_win_v;
  logic [logVcPrio-1:0]          w_win;
  logic                          w_lvl_hit;
  logic [ptr_w-1:0]              w_lvl_v;
  logic [logVcPrio-1:0]          w_bit;
  logic [ptr_w-1:0]              w_next_v;

`ifdef INPUT_ARB_TIMEOUT_EN
  localparam int cnt_w = $clog2(timeout_cycles + 1);
  logic [cnt_w-1:0]              r_to_cnt;
`endif

  // Later (higher) levels overwrite earlier ones; within a level, smaller offsets from the
  // pointer overwrite larger ones, so the first set VC at or after rr_ptr wins.
  always_comb begin
    int idx;
    idx       = 0;
    w_any     = 1'b0;
    w_win_p   = '0;
    w_win_v   = '0;
    w_lvl_hit = 1'b0;
    w_lvl_v   = '0;
    w_bit     = '0;
    for (int p = 0; p < prio_num; p++) begin
      w_lvl_hit = 1'b0;
      w_lvl_v   = '0;
      for (int k = vc_num - 1; k >= 0; k--) begin
        idx = int'(r_rr_ptr[p]) + k;
        if (idx >= vc_num) idx = idx - vc_num;
        w_bit = logVcPrio'(p * vc_num + idx);
        if (has_packet[w_bit]) begin
          w_lvl_hit = 1'b1;
          w_lvl_v   = ptr_w'(idx);
        end
      end
      if (w_lvl_hit) begin
        w_any   = 1'b1;
        w_win_p = prio_w'(p);
        w_win_v = w_lvl_v;
      end
    end
  end

  assign w_win    = logVcPrio'(int'(w_win_p) * vc_num + int'(w_win_v));
  assign w_next_v = (r_sel_v == ptr_w'(vc_num - 1)) ? '0 : r_sel_v + 1'b1;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_sel_p     <= '0;
      r_sel_v     <= '0;
      selected_vc <= '0;
      o_req       <= 1'b0;
      o_dest      <= '0;
      o_output_vc <= '0;
      o_vc_grant  <= '0;
      o_busy      <= 1'b0;
`ifdef INPUT_ARB_TIMEOUT_EN
      r_to_cnt    <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            selected_vc <= w_win;
            r_sel_p     <= w_win_p;
            r_sel_v     <= w_win_v;
            o_dest      <= dest_i[w_win];
            o_output_vc <= output_vc_i[w_win];
            o_req       <= 1'b1;
            r_state     <= ST_REQ;
`ifdef INPUT_ARB_TIMEOUT_EN
            r_to_cnt    <= '0;
`endif
          end
        end
        ST_REQ: begin
          if (cts) begin
            o_req      <= 1'b0;
            o_busy     <= 1'b1;
            o_vc_grant <= N'(1) << selected_vc;
            r_state    <= ST_GRANTED;
          end else if (!has_packet[selected_vc]) begin
            // Withdrawn head-of-line packet: re-arbitrate without charging the level.
            o_req   <= 1'b0;
            r_state <= ST_IDLE;
          end
`ifdef INPUT_ARB_TIMEOUT_EN
          else if (r_to_cnt == cnt_w'(timeout_cycles - 1)) begin
            // Blocked destination: give up and advance the pointer so the level keeps moving.
            o_req              <= 1'b0;
            r_rr_ptr[r_sel_p]  <= w_next_v;
            r_state            <= ST_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
`endif
        end
        ST_GRANTED: begin
          if (last) begin
            o_busy            <= 1'b0;
            o_vc_grant        <= '0;
            r_rr_ptr[r_sel_p] <= w_next_v;
            r_state           <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_dbg_state  = r_state;
  assign o_dbg_rr_ptr = r_rr_ptr;

endmodule

// File: tb/tb_input_vc_arbiter.sv
// Self-checking bench for input_vc_arbiter: directed scenarios plus randomized packets
// checked against a priority/round-robin model of pointers and winners.
module tb_input_vc_arbiter;
  localparam int VC   = 3;
  localparam int PR   = 2;
  localparam int N    = VC * PR;
  localparam int LV   = 3;
  localparam int LO   = 3;
  localparam int PTRW = 2;
`ifdef INPUT_ARB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 64;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_GNT  = 2'd2;

  logic                   clk = 1'b0;
  logic                   resetn;
  logic [N-1:0]           has_packet;
  logic [N-1:0][LO-1:0]   dest_i;
  logic [N-1:0][LV-1:0]   output_vc_i;
  logic                   cts;
  logic                   last;
  logic [LV-1:0]          selected_vc;
  logic                   o_req;
  logic [LO-1:0]          o_dest;
  logic [LV-1:0]          o_output_vc;
  logic [N-1:0]           o_vc_grant;
  logic                   o_busy;
  logic [1:0]             o_dbg_state;
  logic [PR*PTRW-1:0]     o_dbg_rr_ptr;

  input_vc_arbiter #(.vc_num(VC), .prio_num(PR), .output_num(8), .timeout_cycles(TO)) dut (
    .clk(clk), .resetn(resetn), .has_packet(has_packet), .dest_i(dest_i),
    .output_vc_i(output_vc_i), .cts(cts), .last(last), .selected_vc(selected_vc),
    .o_req(o_req), .o_dest(o_dest), .o_output_vc(o_output_vc), .o_vc_grant(o_vc_grant),
    .o_busy(o_busy), .o_dbg_state(o_dbg_state), .o_dbg_rr_ptr(o_dbg_rr_ptr)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int m_ptr[PR];
  int m_dest[N];
  int m_ovc[N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: highest non-empty level, then first set VC at or after that level's pointer.
  function automatic int pick(input int hp);
    for (int p = PR - 1; p >= 0; p--)
      for (int k = 0; k < VC; k++) begin
        int v;
        v = (m_ptr[p] + k) % VC;
        if (((hp >> (p * VC + v)) & 1) == 1) return p * VC + v;
      end
    return -1;
  endfunction

  function automatic logic [31:0] exp_ptrs();
    logic [31:0] r;
    r = 0;
    for (int p = 0; p < PR; p++) r = r | (m_ptr[p] << (p * PTRW));
    return r;
  endfunction

  task automatic drive_payload();
    for (int i = 0; i < N; i++) begin
      dest_i[i]      = LO'(m_dest[i]);
      output_vc_i[i] = LV'(m_ovc[i]);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req"},   o_req, 0);
    chk({tag, "_busy"},  o_busy, 0);
    chk({tag, "_grant"}, o_vc_grant, 0);
    chk({tag, "_sel"},   selected_vc, 0);
    chk({tag, "_dest"},  o_dest, 0);
    chk({tag, "_ovc"},   o_output_vc, 0);
    chk({tag, "_state"}, o_dbg_state, S_IDLE);
    chk({tag, "_ptr"},   o_dbg_rr_ptr, 0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_req"},   o_req, 0);
    chk({tag, "_busy"},  o_busy, 0);
    chk({tag, "_grant"}, o_vc_grant, 0);
    chk({tag, "_state"}, o_dbg_state, S_IDLE);
    chk({tag, "_ptr"},   o_dbg_rr_ptr, exp_ptrs());
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    for (int p = 0; p < PR; p++) m_ptr[p] = 0;
    check_zero("reset");
    resetn = 1'b1;
  endtask

  // One packet: arbitrate, optional stall in REQ, then either withdraw or cts..last.
  task automatic serve(input logic [N-1:0] hp, input int stall, input bit withdraw);
    int e;
    int g;
    e = pick(int'(hp));
    has_packet = hp;
    tick();
    chk("req_valid", o_req, 1);
    chk("req_sel", selected_vc, e);
    chk("req_dest", o_dest, m_dest[e]);
    chk("req_ovc", o_output_vc, m_ovc[e]);
    chk("req_busy", o_busy, 0);
    chk("req_state", o_dbg_state, S_REQ);
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("stall_req", o_req, 1);
      chk("stall_sel", selected_vc, e);
    end
    if (withdraw) begin
      has_packet = hp & ~(N'(1) << e);
      tick();
      check_idle("withdraw");
    end else begin
      cts  = 1'b1;
      last = 1'($urandom_range(0, 1));
      tick();
      cts  = 1'b0;
      last = 1'b0;
      chk("gnt_busy", o_busy, 1);
      chk("gnt_onehot", o_vc_grant, 32'(1) << e);
      chk("gnt_req", o_req, 0);
      chk("gnt_state", o_dbg_state, S_GNT);
      g = $urandom_range(0, 2);
      for (int s = 0; s < g; s++) begin
        has_packet = N'($urandom);
        cts = 1'($urandom_range(0, 1));
        tick();
        chk("gnt_hold", o_vc_grant, 32'(1) << e);
      end
      cts  = 1'b0;
      last = 1'b1;
      tick();
      last = 1'b0;
      m_ptr[e / VC] = (e % VC + 1) % VC;
      check_idle("done");
    end
    has_packet = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; cts = 1'b0; last = 1'b0; has_packet = '0;
    for (int i = 0; i < N; i++) begin
      m_dest[i] = int'($urandom_range(0, 7));
      m_ovc[i]  = int'($urandom_range(0, 5));
    end
    drive_payload();
    tick();
    do_reset();
    tick();
    check_idle("post_reset");

    m_dest[2] = 5; m_ovc[2] = 2;
    drive_payload();
    serve(6'b000100, 0, 0);
    chk("single_dest", o_dest, 5);
    chk("single_ovc", o_output_vc, 2);

    serve(6'b001001, 0, 0);
    chk("prio_sel", selected_vc, 3);
    serve(6'b000001, 0, 0);
    chk("prio_next", selected_vc, 0);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      serve(6'b000111, 0, 0);
      chk("rr_seq", selected_vc, i % 3);
    end

    serve(6'b010000, 1, 1);
    chk("withdraw_sel", selected_vc, 4);

    has_packet = 6'b000010;
    tick();
    chk("rst_mid_sel", selected_vc, 1);
    cts = 1'b1;
    tick();
    cts = 1'b0;
    chk("rst_mid_busy", o_busy, 1);
    do_reset();
    has_packet = 6'b000011;
    tick();
    chk("rst_after_sel", selected_vc, 0);
    chk("rst_after_req", o_req, 1);
    has_packet = '0;
    tick();
    check_idle("rst_after_drop");

`ifdef INPUT_ARB_TIMEOUT_EN
    do_reset();
    has_packet = 6'b000011;
    tick();
    chk("to_sel", selected_vc, 0);
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      chk("to_wait_req", o_req, 1);
    end
    tick();
    m_ptr[0] = 1;
    check_idle("to_expire");
    tick();
    chk("to_next_sel", selected_vc, 1);
    chk("to_next_req", o_req, 1);
    has_packet = '0;
    tick();
    check_idle("to_drop");
`endif

    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) begin
        m_dest[i] = int'($urandom_range(0, 7));
        m_ovc[i]  = int'($urandom_range(0, 5));
      end
      drive_payload();
      serve(N'($urandom_range(1, (1 << N) - 1)), int'($urandom_range(0, 2)),
            ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
